branch_control_sequencer: RTL

//   Hardwired control unit for the Mini SRC datapath covering fetch, br (brzr/brnz/brpl/brmi), jr, nop, halt.

---
 rtl/branch_control_sequencer_if.sv | 28 ++
 rtl/branch_control_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/branch_control_sequencer_if.sv
// Datapath control bundle between the Mini SRC control sequencer (master) and the datapath (slave).
interface branch_control_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [31:0]      IR_Data;
  logic             CON_out;
  logic             mem_rdy;
  logic             PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in, Z_in, Zlow_out;
  logic             Read;
  logic             Gra, Rout, C_out, CON_in;
  logic [4:0]       alu_instruction_bits;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, IR_Data, CON_out, mem_rdy,
    output PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in, Z_in, Zlow_out,
           Read, Gra, Rout, C_out, CON_in, alu_instruction_bits, halted, illegal, retired
  );

  modport slave (
    output run, IR_Data, CON_out, mem_rdy,
    input  PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, IR_in, Y_in, Z_in, Zlow_out,
           Read, Gra, Rout, C_out, CON_in, alu_instruction_bits, halted, illegal, retired
  );
endinterface

// File: rtl/branch_control_sequencer.sv
// Hardwired Mini SRC control unit: fetch, br, jr, nop, halt with Moore step strobes.
// Optional macro MEM_WAIT_EN stretches T1 until mem_rdy; default build assumes fixed-latency RAM.
module branch_control_sequencer #(
  parameter logic [4:0] OP_BR   = 5'b10010,
  parameter logic [4:0] OP_JR   = 5'b10011,
  parameter logic [4:0] OP_NOP  = 5'b11001,
  parameter logic [4:0] OP_HALT = 5'b11010,
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter int         CNT_W   = 16
) (
  input logic                         clk,
  input logic                         clr,
  branch_control_sequencer_if.master  bus
);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t           state, state_nxt, after_instr;
  logic [CNT_W-1:0] retired;
  logic             retire;
  logic [4:0]       opcode;
  logic             unused_bits;

  assign opcode = bus.IR_Data[31:27];
`ifdef MEM_WAIT_EN
  assign unused_bits = &{1'b0, bus.IR_Data[26:0]};
`else
  assign unused_bits = &{1'b0, bus.IR_Data[26:0], bus.mem_rdy};
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // run is only looked at once an instruction has finished
  assign after_instr = bus.run ? T0 : IDLE;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired <= sat_inc(retired);
    end
  end

  assign bus.retired = retired;

  always_comb begin
    state_nxt                = state;
    retire                   = 1'b0;
    bus.PC_out               = 1'b0;
    bus.PC_in                = 1'b0;
    bus.IncPC                = 1'b0;
    bus.MAR_in               = 1'b0;
    bus.MDR_in               = 1'b0;
    bus.MDR_out              = 1'b0;
    bus.IR_in                = 1'b0;
    bus.Y_in                 = 1'b0;
    bus.Z_in                 = 1'b0;
    bus.Zlow_out             = 1'b0;
    bus.Read                 = 1'b0;
    bus.Gra                  = 1'b0;
    bus.Rout                 = 1'b0;
    bus.C_out                = 1'b0;
    bus.CON_in               = 1'b0;
    bus.alu_instruction_bits = 5'b00000;
    bus.halted               = 1'b0;
    bus.illegal              = 1'b0;
    case (state)
      IDLE: if (bus.run) state_nxt = T0;
      T0: begin
        bus.PC_out = 1'b1;
        bus.MAR_in = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Z_in   = 1'b1;
        state_nxt  = T1;
      end
      T1: begin
        bus.Read   = 1'b1;
        bus.MDR_in = 1'b1;
`ifdef MEM_WAIT_EN
        // PC takes the incremented value only in the cycle the read completes
        if (bus.mem_rdy) begin
          bus.Zlow_out = 1'b1;
          bus.PC_in    = 1'b1;
          state_nxt    = T2;
        end
`else
        bus.Zlow_out = 1'b1;
        bus.PC_in    = 1'b1;
        state_nxt    = T2;
`endif
      end
      T2: begin
        bus.MDR_out = 1'b1;
        bus.IR_in   = 1'b1;
        state_nxt   = T3;
      end
      T3: begin
        if (opcode == OP_BR) begin
          bus.Gra    = 1'b1;
          bus.Rout   = 1'b1;
          bus.CON_in = 1'b1;
          state_nxt  = T4;
        end else if (opcode == OP_JR) begin
          bus.Gra   = 1'b1;
          bus.Rout  = 1'b1;
          bus.PC_in = 1'b1;
          retire    = 1'b1;
          state_nxt = after_instr;
        end else if (opcode == OP_NOP) begin
          retire    = 1'b1;
          state_nxt = after_instr;
        end else if (opcode == OP_HALT) begin
          retire    = 1'b1;
          state_nxt = HALT;
        end else begin
          bus.illegal = 1'b1;
          state_nxt   = after_instr;
        end
      end
      T4: begin
        bus.PC_out = 1'b1;
        bus.Y_in   = 1'b1;
        state_nxt  = T5;
      end
      T5: begin
        bus.C_out                = 1'b1;
        bus.Z_in                 = 1'b1;
        bus.alu_instruction_bits = ALU_ADD;
        state_nxt                = T6;
      end
      T6: begin
        // a false condition leaves PC at the already-incremented fetch address
        bus.Zlow_out = 1'b1;
        bus.PC_in    = bus.CON_out;
        retire       = 1'b1;
        state_nxt    = after_instr;
      end
      HALT: bus.halted = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
